// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display slice.
// Holds segment patterns (bit0 = A ... bit6 = G, active-high), the digit
// slot indices used on the DIG lines, and the capture FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_6_ALT = 7'h7C;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_9_ALT = 7'h67;

  localparam logic [1:0] DIG_S_ONES = 2'd0;
  localparam logic [1:0] DIG_S_TENS = 2'd1;
  localparam logic [1:0] DIG_M_ONES = 2'd2;
  localparam logic [1:0] DIG_M_TENS = 2'd3;

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    HELD
  } captureState_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD decoder.
// Ports:
//   pattern - 7-bit segment pattern, bit0 = A ... bit6 = G
//   value   - decoded BCD digit (0 when the pattern is not recognised)
//   valid   - high when pattern is one of the accepted digit shapes
// A blank pattern decodes as 0 so that leading-zero blanking still reads back.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       valid
);

  always_comb begin
    value = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0, SEG_BLANK:   value = 4'd0;
      SEG_1:              value = 4'd1;
      SEG_2:              value = 4'd2;
      SEG_3:              value = 4'd3;
      SEG_4:              value = 4'd4;
      SEG_5:              value = 4'd5;
      SEG_6, SEG_6_ALT:   value = 4'd6;
      SEG_7, SEG_7_ALT:   value = 4'd7;
      SEG_8:              value = 4'd8;
      SEG_9, SEG_9_ALT:   value = 4'd9;
      default:            valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_display_capture.sv
// Receiving end of the multiplexed 7-segment display interface.
// Synchronizes the segment lines and digit index, waits for each digit slot
// to sit still for STABLE_CYCLES samples, decodes it and assembles a full
// minutes:seconds frame once every slot has been seen.
// Ports:
//   CLK, RST     - clock, asynchronous active-low reset
//   A..G         - segment lines (active-high), asynchronous
//   DIG          - digit slot index, asynchronous
//   S_ONES..M_TENS - captured BCD digits, held between frames
//   FRAME_VALID  - one-cycle pulse when the four digits update together
//   DIGIT_ERR    - one-cycle pulse on a stable but undecodable pattern
//   LOCKED       - set by a complete frame, cleared by the timeout
module mux_display_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic [1:0] DIG,
  output logic [3:0] S_ONES,
  output logic [3:0] S_TENS,
  output logic [3:0] M_ONES,
  output logic [3:0] M_TENS,
  output logic       FRAME_VALID,
  output logic       DIGIT_ERR,
  output logic       LOCKED
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] STABLE_MAX   = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    rstPipe;
  logic          rstN;
  logic [8:0]    pinBus;
  logic [8:0]    syncPipe [SYNC_STAGES];
  logic [8:0]    s;
  logic [8:0]    sPrev;
  logic          sChanged;
  logic [CW-1:0] cntReg;
  logic [CW-1:0] cnt;
  captureState_e state, nextState;
  logic          accept;
  logic [3:0]    decValue;
  logic          decValid;
  logic          validAccept;
  logic          invalidAccept;
  logic [1:0]    sDig;
  logic [3:0]    mask;
  logic [3:0]    maskNext;
  logic [3:0]    shadow [4];
  logic [TW-1:0] toCnt;
  logic          expire;
  logic          frameDone;

  // Reset asserts immediately but releases on a clock edge, so no flop
  // leaves reset in a different cycle from its neighbours.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rstPipe <= 2'b00;
    else      rstPipe <= {rstPipe[0], 1'b1};
  end

  assign rstN   = rstPipe[1];
  assign pinBus = {DIG, G, F, E, D, C, B, A};

  // Input synchronizer; the last stage is the sample the rest of the
  // design works on.
  always_ff @(posedge CLK or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncPipe[i] <= '0;
    end else begin
      syncPipe[0] <= pinBus;
      for (int i = 1; i < SYNC_STAGES; i++) syncPipe[i] <= syncPipe[i-1];
    end
  end

  assign s        = syncPipe[SYNC_STAGES-1];
  assign sChanged = (s != sPrev);
  assign sDig     = s[8:7];

  // cnt is the length of the current run of identical samples including
  // this cycle's; cntReg remembers it for the next cycle.
  always_comb begin
    if (sChanged)                cnt = CW'(1);
    else if (cntReg < STABLE_MAX) cnt = cntReg + CW'(1);
    else                         cnt = cntReg;
  end

  always_ff @(posedge CLK or negedge rstN) begin
    if (!rstN) begin
      sPrev  <= '0;
      cntReg <= '0;
      state  <= WAIT;
    end else begin
      sPrev  <= s;
      cntReg <= cnt;
      state  <= nextState;
    end
  end

  // Debounce FSM: one accept per stable run; any change re-arms it.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    unique case (state)
      WAIT: begin
        if (sChanged) nextState = SETTLE;
      end
      SETTLE: begin
        if (cnt == STABLE_MAX) begin
          accept    = 1'b1;
          nextState = HELD;
        end
      end
      HELD: begin
        if (sChanged) nextState = SETTLE;
      end
      default: nextState = WAIT;
    endcase
  end

  seg7_to_bcd decoder (
    .pattern(s[6:0]),
    .value  (decValue),
    .valid  (decValid)
  );

  assign validAccept   = accept & decValid;
  assign invalidAccept = accept & ~decValid;
  assign frameDone     = (mask == 4'hF);

  // A valid accept clears the counter in the same cycle, so it always beats
  // an expiring timeout and can still complete the frame.
  assign expire = !validAccept && (toCnt == TIMEOUT_LAST);

  // A completed frame or a timeout empties the mask, but a digit accepted
  // in that same cycle still lands in the fresh mask.
  always_comb begin
    maskNext = mask;
    if (frameDone || expire) maskNext = 4'h0;
    if (validAccept) maskNext[sDig] = 1'b1;
  end

  always_ff @(posedge CLK or negedge rstN) begin
    if (!rstN) begin
      mask        <= 4'h0;
      toCnt       <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= 4'd0;
      S_ONES      <= 4'd0;
      S_TENS      <= 4'd0;
      M_ONES      <= 4'd0;
      M_TENS      <= 4'd0;
      FRAME_VALID <= 1'b0;
      DIGIT_ERR   <= 1'b0;
      LOCKED      <= 1'b0;
    end else begin
      mask        <= maskNext;
      FRAME_VALID <= frameDone;
      DIGIT_ERR   <= invalidAccept;
      if (validAccept)              toCnt <= '0;
      else if (toCnt < TIMEOUT_MAX) toCnt <= toCnt + TW'(1);
      if (validAccept) shadow[sDig] <= decValue;
      if (frameDone) begin
        S_ONES <= shadow[DIG_S_ONES];
        S_TENS <= shadow[DIG_S_TENS];
        M_ONES <= shadow[DIG_M_ONES];
        M_TENS <= shadow[DIG_M_TENS];
        LOCKED <= 1'b1;
      end else if (expire) begin
        LOCKED <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_display_capture.sv
// Directed scoreboard bench for mux_display_capture.
module tb_mux_display_capture;

  logic       CLK;
  logic       RST;
  logic [6:0] segs;
  logic [1:0] DIG;
  logic [3:0] S_ONES, S_TENS, M_ONES, M_TENS;
  logic       FRAME_VALID, DIGIT_ERR, LOCKED;

  int vectors = 0;
  int miscompares = 0;
  int frameCount = 0;
  int errCount = 0;

  logic [3:0]  tbShadow [4];
  logic [3:0]  tbMask;
  logic [15:0] expQ [$];

  mux_display_capture #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(64),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .A          (segs[0]),
    .B          (segs[1]),
    .C          (segs[2]),
    .D          (segs[3]),
    .E          (segs[4]),
    .F          (segs[5]),
    .G          (segs[6]),
    .DIG        (DIG),
    .S_ONES     (S_ONES),
    .S_TENS     (S_TENS),
    .M_ONES     (M_ONES),
    .M_TENS     (M_TENS),
    .FRAME_VALID(FRAME_VALID),
    .DIGIT_ERR  (DIGIT_ERR),
    .LOCKED     (LOCKED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit tbDecode(input logic [6:0] p, output logic [3:0] v);
    bit ok;
    ok = 1'b1;
    v  = 4'd0;
    case (p)
      7'h3F, 7'h00: v = 4'd0;
      7'h06:        v = 4'd1;
      7'h5B:        v = 4'd2;
      7'h4F:        v = 4'd3;
      7'h66:        v = 4'd4;
      7'h6D:        v = 4'd5;
      7'h7D, 7'h7C: v = 4'd6;
      7'h07, 7'h27: v = 4'd7;
      7'h7F:        v = 4'd8;
      7'h6F, 7'h67: v = 4'd9;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Drive one digit slot; when it is held long enough to settle, fold it
  // into the reference frame and queue the frame once all slots are seen.
  task automatic applyStimulus(input logic [1:0] dig, input logic [6:0] pat, input int cycles, input bit settles);
    logic [3:0] v;
    bit ok;
    DIG  = dig;
    segs = pat;
    if (settles) begin
      ok = tbDecode(pat, v);
      if (ok) begin
        tbShadow[dig] = v;
        tbMask[dig]   = 1'b1;
        if (tbMask == 4'hF) begin
          expQ.push_back({tbShadow[3], tbShadow[2], tbShadow[1], tbShadow[0]});
          tbMask = 4'h0;
        end
      end
    end
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n;
    n = 0;
    while (frameCount < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("frameCount", frameCount, target);
  endtask

  // Frame monitor: pops the scoreboard on every FRAME_VALID pulse.
  always @(posedge CLK) begin
    logic [15:0] exp;
    #1;
    if (DIGIT_ERR) errCount++;
    if (FRAME_VALID) begin
      frameCount++;
      checkOutput("framePending", expQ.size() > 0, 1);
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        checkOutput("frameDigits", {M_TENS, M_ONES, S_TENS, S_ONES}, exp);
        checkOutput("lockedAtFrame", LOCKED, 1);
      end
    end
  end

  initial begin
    int n;
    RST    = 1'b0;
    segs   = 7'h00;
    DIG    = 2'd0;
    tbMask = 4'h0;
    for (int i = 0; i < 4; i++) tbShadow[i] = 4'd0;
    repeat (4) @(negedge CLK);
    checkOutput("resetDigits", {M_TENS, M_ONES, S_TENS, S_ONES}, 16'h0000);
    checkOutput("resetFrameValid", FRAME_VALID, 0);
    checkOutput("resetDigitErr", DIGIT_ERR, 0);
    checkOutput("resetLocked", LOCKED, 0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    // Nominal scan 5,2,1,3
    applyStimulus(2'd0, 7'h6D, 8, 1);
    applyStimulus(2'd1, 7'h5B, 8, 1);
    applyStimulus(2'd2, 7'h06, 8, 1);
    applyStimulus(2'd3, 7'h4F, 8, 1);
    waitFrames(1, 20);
    checkOutput("nominalLocked", LOCKED, 1);
    checkOutput("nominalDigits", {M_TENS, M_ONES, S_TENS, S_ONES}, 16'h3125);

    // Glitching slot 0 then steady 8; alternate 6/7 shapes and a blank
    for (int i = 0; i < 10; i++) applyStimulus(2'd0, 7'h7F ^ (7'h01 << (i % 7)), 2, 0);
    applyStimulus(2'd0, 7'h7F, 8, 1);
    applyStimulus(2'd1, 7'h7C, 8, 1);
    applyStimulus(2'd2, 7'h27, 8, 1);
    applyStimulus(2'd3, 7'h00, 8, 1);
    waitFrames(2, 20);
    checkOutput("glitchNoDigitErr", errCount, 0);
    checkOutput("alternateDigits", {M_TENS, M_ONES, S_TENS, S_ONES}, 16'h0768);

    // Overwrite of slot 0 and an undecodable pattern in slot 1
    applyStimulus(2'd0, 7'h06, 8, 1);
    applyStimulus(2'd2, 7'h4F, 8, 1);
    applyStimulus(2'd3, 7'h5B, 8, 1);
    applyStimulus(2'd0, 7'h3F, 8, 1);
    applyStimulus(2'd1, 7'h49, 10, 1);
    checkOutput("invalidDigitErr", errCount, 1);
    checkOutput("invalidNoFrame", frameCount, 2);
    applyStimulus(2'd1, 7'h66, 8, 1);
    waitFrames(3, 20);

    // Reset during a partial frame
    applyStimulus(2'd0, 7'h6D, 8, 1);
    applyStimulus(2'd1, 7'h5B, 8, 1);
    RST  = 1'b0;
    segs = 7'h00;
    DIG  = 2'd0;
    #1;
    checkOutput("midResetDigits", {M_TENS, M_ONES, S_TENS, S_ONES}, 16'h0000);
    checkOutput("midResetLocked", LOCKED, 0);
    tbMask = 4'h0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    applyStimulus(2'd2, 7'h7D, 8, 1);
    applyStimulus(2'd3, 7'h06, 8, 1);
    repeat (4) @(negedge CLK);
    checkOutput("partialAfterReset", frameCount, 3);
    applyStimulus(2'd0, 7'h4F, 8, 1);

    // Latency of the completing digit, then the timeout after it
    applyStimulus(2'd1, 7'h6F, 0, 1);
    n = 0;
    while (!FRAME_VALID && n < 30) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("frameLatency", n, 7);
    while (LOCKED && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("timeoutCycles", n, 70);
    checkOutput("holdAfterTimeout", {M_TENS, M_ONES, S_TENS, S_ONES}, 16'h1693);
    checkOutput("framesBeforeRelock", frameCount, 4);

    // Fresh scan relocks
    applyStimulus(2'd0, 7'h6D, 8, 1);
    applyStimulus(2'd1, 7'h5B, 8, 1);
    applyStimulus(2'd2, 7'h06, 8, 1);
    applyStimulus(2'd3, 7'h4F, 8, 1);
    waitFrames(5, 20);
    checkOutput("relocked", LOCKED, 1);

    // Last digit accepted in the very cycle the timeout would expire
    applyStimulus(2'd0, 7'h3F, 8, 1);
    applyStimulus(2'd1, 7'h06, 8, 1);
    applyStimulus(2'd2, 7'h5B, 64, 1);
    applyStimulus(2'd3, 7'h4F, 8, 1);
    waitFrames(6, 20);
    checkOutput("tieLocked", LOCKED, 1);
    checkOutput("tieDigits", {M_TENS, M_ONES, S_TENS, S_ONES}, 16'h3210);
    checkOutput("digitErrTotal", errCount, 1);
    checkOutput("scoreboardDrained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_display_capture.md
Name: mux_display_capture

Overview:
- Receiving end of the team's multiplexed 7-segment display interface: samples the time-multiplexed segment lines A..G plus the 2-bit digit index.
- Debounces each digit slot, decodes segment patterns back to BCD, and reassembles the four-digit minutes:seconds value (M_TENS M_ONES : S_TENS S_ONES).
- Sits at the board/pad boundary. All inputs are asynchronous to CLK and are synchronized internally.
- Used for loopback self-test of the counter display and as a display-scraping front end.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical synchronized samples {DIG, A..G} needed to accept a digit. Minimum 2.
- TIMEOUT_CYCLES, 65536: cycles with no accepted digit before lock is dropped.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizer. Minimum 2.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- A..G  input  1 each  segment lines, active-high, A = top, G = middle.
- DIG  input  2  digit index: 0 = S_ONES, 1 = S_TENS, 2 = M_ONES, 3 = M_TENS.
- S_ONES  output  4  captured seconds-ones BCD.
- S_TENS  output  4  captured seconds-tens BCD.
- M_ONES  output  4  captured minutes-ones BCD.
- M_TENS  output  4  captured minutes-tens BCD.
- FRAME_VALID  output  1  one-cycle pulse when all four outputs are updated together.
- DIGIT_ERR  output  1  one-cycle pulse on an accepted-stable but undecodable pattern.
- LOCKED  output  1  high after the first complete frame; low after a timeout.

Behaviour:
- Reset (RST = 0, asynchronous):
  - all digit outputs, shadow registers, capture mask and counters are 0;
  - FRAME_VALID, DIGIT_ERR and LOCKED are 0;
  - the FSM goes to WAIT.
- Reset release is synchronized. Reset mid-frame discards the partial capture.
- Synchronizer: SYNC_STAGES flops on each of the 9 inputs. The last-stage 9-bit sample is called s.
- Stability counter:
  - cnt loads 1 when s differs from the previous s; otherwise it increments, saturating at STABLE_CYCLES.
- FSM:
  - WAIT: go to SETTLE on any change of s.
  - SETTLE: when cnt reaches STABLE_CYCLES, raise a one-cycle accept and go to HELD. A change of s before then restarts the count and stays in SETTLE.
  - HELD: go to SETTLE on any change of s. A stable run yields exactly one accept.
- Decode on accept:
  - bit0 = A … bit6 = G.
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D or 0x7C, 7 = 0x07 or 0x27, 8 = 0x7F, 9 = 0x6F or 0x67.
  - Blank 0x00 decodes as 0.
  - Any other pattern is invalid.
- Valid accept: write the decoded value into shadow[DIG] and set mask[DIG]. Re-accepting the same index before the frame completes overwrites the shadow value.
- Invalid accept: DIGIT_ERR pulses on the next cycle. Shadow and mask are unchanged.
- Frame completion:
  - when the mask becomes 4'hF, the next edge copies all four shadows to the outputs simultaneously, pulses FRAME_VALID, sets LOCKED and clears the mask;
  - digit order is irrelevant;
  - the outputs hold between frames.
- Latency: from a pin change that completes a frame to FRAME_VALID = SYNC_STAGES + STABLE_CYCLES + 1 cycles.
- Timeout:
  - a counter clears on every valid accept and saturates at TIMEOUT_CYCLES;
  - on reaching TIMEOUT_CYCLES, LOCKED goes to 0 and the mask clears;
  - digit outputs keep their last values;
  - TIMEOUT_CYCLES is reached again only after a new accept.
- Simultaneous events: a valid accept that sets the last mask bit in the same cycle as the timeout expiring: the accept wins, the frame completes and LOCKED stays 1.
- Arithmetic: the counters are sized to their parameter (clog2 + 1). No wrap-around occurs; the counters saturate.

Decomposition:
- Package seg7_pkg holds:
  - the segment pattern localparams (SEG_0..SEG_9, alternates, SEG_BLANK);
  - digit-index constants DIG_S_ONES..DIG_M_TENS;
  - the FSM state encoding (WAIT, SETTLE, HELD).
- Sub-module seg7_to_bcd: combinational, 7-bit pattern in, 4-bit value + valid flag out. It is shared with the future display-checker.
- Synchronizer, stability counter, FSM, mask/shadow and timeout live in the top module.

Test Plan:
- Reset: drive RST low mid-frame → all outputs 0, LOCKED 0. After release, a full frame is still required before FRAME_VALID.
- Nominal scan: present DIG 0..3 with 0x6D, 0x5B, 0x06, 0x4F (5, 2, 1, 3), each for 8 cycles, STABLE_CYCLES = 4 → one FRAME_VALID pulse; S_ONES = 5, S_TENS = 2, M_ONES = 1, M_TENS = 3; LOCKED = 1.
- Glitch rejection: change a segment every 2 cycles for 20 cycles on DIG = 0, then hold 0x7F → only 8 is captured; no DIGIT_ERR.
- Invalid pattern: hold 0x49 for 6 cycles → exactly one DIGIT_ERR pulse; mask unchanged; no FRAME_VALID.
- Alternates and blank: M_TENS slot = 0x00, S_ONES slot = 0x67 → M_TENS = 0, S_ONES = 9.
- Timeout: TIMEOUT_CYCLES = 64; stop the scan after lock → LOCKED falls 64 cycles after the last accept and the outputs hold. The next full scan raises LOCKED again.
